fb_access_scheduler: RTL and testbench

- Shares one single-port, double-banked frame memory between the display scan-out reader and the Gaussian blur image processor.
- Sequences processing runs and swaps the front/back banks only at display frame boundaries.
- The display reads the front bank. The processor reads its source pixels from the front bank and writes blurred pixels to the back bank.
- Sits between the display timing logic, image_processor and the frame RAM.

---
 rtl/fb_access_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_fb_access_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_access_scheduler.sv
// fb_access_scheduler
//   Arbitrates one single-port, double-banked frame memory between the display
//   scan-out reader and the blur processor. It also sequences processing runs
//   and swaps the front/back banks only at display frame boundaries.
//
// Ports
//   clk, rst               system clock, asynchronous active-low reset
//   disp_*                 display read port (request/grant, rdata/rvalid)
//   disp_frame_start       one-cycle pulse at the start of each display frame
//   proc_*                 processor read/write port (request/grant, rdata/rvalid)
//   proc_done              processor finished its frame (level)
//   run_en                 continuous processing enable
//   start_process          one-cycle start pulse to the processor
//   mem_*                  frame RAM port; mem_addr = {bank, pixel address}
//   front_bank             bank currently scanned out by the display
//   swap_count             completed bank swaps (wrapping)
//
// Sequencing FSM
//   state       | meaning
//   S_IDLE      | no run active; start one when run_en is high
//   S_RUN       | processor is computing the back bank
//   S_WAIT_SWAP | frame done; waiting for a clean display frame start to swap
module fb_access_scheduler #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 24,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              disp_frame_start,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_gnt,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              proc_rvalid,
  input  logic              proc_done,
  input  logic              run_en,
  output logic              start_process,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              front_bank,
  output logic [CNT_W-1:0]  swap_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_WAIT_SWAP = 2'd2
  } state_t;

  state_t              state_q;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                wait_max;
  logic                proc_win;

  logic                mem_en_q, mem_we_q, src_proc_q;
  logic [ADDR_W:0]     mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                disp_rvalid_q, proc_rvalid_q;

  logic                start_q, front_q;
  logic [CNT_W-1:0]    swap_cnt_q;
  logic                swap_ok;

  // ---------------------------------------------------------------------------
  // Arbitration: display first, unless the processor has starved MAX_WAIT cycles.
  // Grants are forced low while reset is held so every output reads 0 in reset.
  // ---------------------------------------------------------------------------
  assign wait_max = (wait_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    proc_win = proc_req && (!disp_req || wait_max);
    proc_gnt = rst && proc_win;
    disp_gnt = rst && disp_req && !proc_win;
  end

  always_comb begin
    wait_d = wait_q;
    if (!proc_req || proc_gnt) begin
      wait_d = '0;
    end else if (!wait_max) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Access pipeline: grant -> registered memory command -> rvalid with live
  // mem_rdata. The bank is resolved at grant time, so a later swap cannot
  // retarget an access already accepted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      src_proc_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      disp_rvalid_q <= 1'b0;
      proc_rvalid_q <= 1'b0;
    end else begin
      mem_en_q   <= disp_gnt || proc_gnt;
      mem_we_q   <= proc_gnt && proc_we;
      src_proc_q <= proc_gnt;
      if (proc_gnt) begin
        mem_addr_q <= {(proc_we ? ~front_q : front_q), proc_addr};
        if (proc_we) begin
          mem_wdata_q <= proc_wdata;
        end
      end else if (disp_gnt) begin
        mem_addr_q <= {front_q, disp_addr};
      end
      disp_rvalid_q <= mem_en_q && !mem_we_q && !src_proc_q;
      proc_rvalid_q <= mem_en_q && !mem_we_q && src_proc_q;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_rvalid = disp_rvalid_q;
  assign proc_rvalid = proc_rvalid_q;
  // Read data is the RAM output of this cycle, masked so idle cycles read as 0.
  assign disp_rdata  = disp_rvalid_q ? mem_rdata : '0;
  assign proc_rdata  = proc_rvalid_q ? mem_rdata : '0;

  // ---------------------------------------------------------------------------
  // Sequencing FSM. A swap needs a frame start with the processor quiet and no
  // processor write still sitting in the memory command stage; otherwise the
  // write could land in what just became the front bank.
  // ---------------------------------------------------------------------------
  assign swap_ok = disp_frame_start && !proc_req && !(mem_en_q && mem_we_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      front_q    <= 1'b0;
      swap_cnt_q <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run_en) begin
            start_q <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (proc_done) begin
            state_q <= S_WAIT_SWAP;
          end
        end
        S_WAIT_SWAP: begin
          if (swap_ok) begin
            front_q    <= ~front_q;
            swap_cnt_q <= swap_cnt_q + 1'b1;
            if (run_en) begin
              start_q <= 1'b1;
              state_q <= S_RUN;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_process = start_q;
  assign front_bank    = front_q;
  assign swap_count    = swap_cnt_q;

endmodule

// File: tb/tb_fb_access_scheduler.sv
module tb_fb_access_scheduler;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 24;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic              disp_gnt;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              disp_frame_start = 1'b0;
  logic              proc_req = 1'b0;
  logic              proc_we = 1'b0;
  logic [ADDR_W-1:0] proc_addr = '0;
  logic [DATA_W-1:0] proc_wdata = '0;
  logic              proc_gnt;
  logic [DATA_W-1:0] proc_rdata;
  logic              proc_rvalid;
  logic              proc_done = 1'b0;
  logic              run_en = 1'b0;
  logic              start_process;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              front_bank;
  logic [CNT_W-1:0]  swap_count;

  int n_chk  = 0;
  int n_fail = 0;

  fb_access_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .disp_frame_start(disp_frame_start),
    .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_gnt(proc_gnt), .proc_rdata(proc_rdata),
    .proc_rvalid(proc_rvalid), .proc_done(proc_done), .run_en(run_en),
    .start_process(start_process),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .front_bank(front_bank), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  // Frame RAM: contents are a fixed function of the full {bank, addr}.
  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W:0] a);
    return {a[7:0] ^ 8'h5A, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_val(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model + scoreboard, evaluated on the falling edge.
  // ---------------------------------------------------------------------------
  logic              m_front = 1'b0;
  int                m_wait = 0;
  logic              m_en = 1'b0, m_we = 1'b0, m_src = 1'b0;
  logic [ADDR_W:0]   m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic              m_drv = 1'b0, m_prv = 1'b0;
  logic [DATA_W-1:0] dq[$];
  logic [DATA_W-1:0] pq[$];
  logic              eg_d, eg_p;
  logic [DATA_W-1:0] exp_d;

  always @(negedge clk) begin
    if (!rst) begin
      m_front = 1'b0; m_wait = 0;
      m_en = 1'b0; m_we = 1'b0; m_src = 1'b0; m_drv = 1'b0; m_prv = 1'b0;
      dq.delete(); pq.delete();
    end else begin
      eg_p = proc_req && (!disp_req || m_wait == MAX_WAIT);
      eg_d = disp_req && !eg_p;
      check("disp_gnt", disp_gnt, eg_d);
      check("proc_gnt", proc_gnt, eg_p);
      check("mem_en", mem_en, m_en);
      if (m_en) begin
        check("mem_we", mem_we, m_we);
        check("mem_addr", mem_addr, m_addr);
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
      check("disp_rvalid", disp_rvalid, m_drv);
      if (m_drv) begin
        check("disp_sb_nonempty", dq.size() != 0, 1);
        if (dq.size() != 0) begin
          exp_d = dq.pop_front();
          check("disp_rdata", disp_rdata, exp_d);
        end
      end
      check("proc_rvalid", proc_rvalid, m_prv);
      if (m_prv) begin
        check("proc_sb_nonempty", pq.size() != 0, 1);
        if (pq.size() != 0) begin
          exp_d = pq.pop_front();
          check("proc_rdata", proc_rdata, exp_d);
        end
      end
      // advance model by one cycle
      m_drv = m_en && !m_we && !m_src;
      m_prv = m_en && !m_we && m_src;
      m_en  = eg_d || eg_p;
      m_src = eg_p;
      m_we  = eg_p && proc_we;
      if (eg_p) begin
        m_addr = {(proc_we ? ~m_front : m_front), proc_addr};
        if (proc_we) m_wdata = proc_wdata;
        else pq.push_back(mem_val({m_front, proc_addr}));
      end else if (eg_d) begin
        m_addr = {m_front, disp_addr};
        dq.push_back(mem_val({m_front, disp_addr}));
      end
      if (!proc_req || eg_p) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [CNT_W-1:0] m_cnt;

  initial begin
    // reset state
    repeat (2) cyc();
    check("rst_disp_gnt", disp_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_front", front_bank, 0);
    check("rst_swap_cnt", swap_count, 0);
    check("rst_start", start_process, 0);
    rst = 1'b1;
    repeat (2) cyc();

    // continuous contention: D,D,D,D,P repeating
    for (int i = 0; i < 15; i++) begin
      disp_req  = 1'b1; disp_addr = ADDR_W'(16'h0100 + i);
      proc_req  = 1'b1; proc_we = 1'b0; proc_addr = ADDR_W'(16'h0200 + i);
      #1;
      check("arb_pattern", proc_gnt, (i % 5) == 4);
      cyc();
    end
    disp_req = 1'b0; proc_req = 1'b0;
    repeat (3) cyc();

    // processor write to back bank, display read of front bank
    proc_req = 1'b1; proc_we = 1'b1; proc_addr = 15'h1234; proc_wdata = 24'hABCDEF;
    cyc();
    proc_req = 1'b0; proc_we = 1'b0;
    check("wr_mem_en", mem_en, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 16'h9234);
    check("wr_mem_wdata", mem_wdata, 24'hABCDEF);
    disp_req = 1'b1; disp_addr = 15'h1234;
    cyc();
    disp_req = 1'b0;
    check("rd_mem_addr", mem_addr, 16'h1234);
    check("rd_mem_we", mem_we, 0);
    cyc();
    check("rd_rvalid", disp_rvalid, 1);
    check("rd_rdata", disp_rdata, mem_val(16'h1234));
    repeat (2) cyc();
    check("idle_no_start", start_process, 0);

    // IDLE -> RUN with a single start pulse; swap 10 cycles after proc_done
    run_en = 1'b1;
    cyc();
    check("start_pulse1", start_process, 1);
    cyc();
    check("start_single", start_process, 0);
    repeat (3) cyc();
    proc_done = 1'b1;
    cyc();
    proc_done = 1'b0;
    repeat (9) cyc();
    check("pre_swap_front", front_bank, 0);
    disp_frame_start = 1'b1;
    cyc();
    disp_frame_start = 1'b0;
    m_front = 1'b1;
    check("swap1_front", front_bank, 1);
    check("swap1_cnt", swap_count, 1);
    check("start_pulse2", start_process, 1);
    cyc();
    check("start_pulse2_end", start_process, 0);

    // proc_done coincident with frame start: no swap yet
    proc_done = 1'b1; disp_frame_start = 1'b1;
    cyc();
    proc_done = 1'b0; disp_frame_start = 1'b0;
    check("coinc_front", front_bank, 1);
    check("coinc_cnt", swap_count, 1);
    repeat (2) cyc();
    // frame start while a processor write is in flight: deferred
    proc_req = 1'b1; proc_we = 1'b1; proc_addr = 15'h0042; proc_wdata = 24'h123456;
    cyc();
    proc_req = 1'b0; proc_we = 1'b0;
    disp_frame_start = 1'b1;
    cyc();
    disp_frame_start = 1'b0;
    check("wrflight_front", front_bank, 1);
    check("wrflight_cnt", swap_count, 1);
    check("wrflight_start", start_process, 0);
    repeat (2) cyc();
    disp_frame_start = 1'b1;
    cyc();
    disp_frame_start = 1'b0;
    m_front = 1'b0;
    check("swap2_front", front_bank, 0);
    check("swap2_cnt", swap_count, 2);
    check("swap2_start", start_process, 1);
    cyc();

    // run_en dropped during RUN: frame completes, swap, back to IDLE
    run_en = 1'b0;
    cyc();
    proc_done = 1'b1;
    cyc();
    proc_done = 1'b0;
    repeat (3) cyc();
    check("stop_pre_front", front_bank, 0);
    disp_frame_start = 1'b1;
    cyc();
    disp_frame_start = 1'b0;
    m_front = 1'b1;
    check("stop_front", front_bank, 1);
    check("stop_cnt", swap_count, 3);
    check("stop_no_start", start_process, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("idle_hold_start", start_process, 0);
    end

    // swap counter wrap
    run_en = 1'b1;
    cyc();
    check("wrap_start", start_process, 1);
    m_cnt = 8'd3;
    for (int i = 0; i < 254; i++) begin
      proc_done = 1'b1;
      cyc();
      proc_done = 1'b0; disp_frame_start = 1'b1;
      cyc();
      disp_frame_start = 1'b0;
      m_front = ~m_front;
      m_cnt = m_cnt + 1'b1;
      check("wrap_cnt", swap_count, m_cnt);
      check("wrap_front", front_bank, m_front);
    end
    run_en = 1'b0;

    // reset with reads in flight
    disp_req = 1'b1; disp_addr = 15'h0777;
    proc_req = 1'b1; proc_we = 1'b0; proc_addr = 15'h0555;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    check("mrst_disp_gnt", disp_gnt, 0);
    check("mrst_proc_gnt", proc_gnt, 0);
    check("mrst_mem_en", mem_en, 0);
    check("mrst_mem_addr", mem_addr, 0);
    check("mrst_disp_rvalid", disp_rvalid, 0);
    check("mrst_proc_rvalid", proc_rvalid, 0);
    check("mrst_disp_rdata", disp_rdata, 0);
    check("mrst_front", front_bank, 0);
    check("mrst_cnt", swap_count, 0);
    disp_req = 1'b0; proc_req = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("post_rst_drv", disp_rvalid, 0);
      check("post_rst_prv", proc_rvalid, 0);
      check("post_rst_start", start_process, 0);
    end
    check("post_rst_front", front_bank, 0);
    run_en = 1'b1;
    cyc();
    check("post_rst_start_pulse", start_process, 1);
    cyc();
    check("post_rst_start_end", start_process, 0);
    run_en = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
